// File: rtl/ras_ckpt_stack.sv
// rtl/ras_ckpt_stack.sv - circular return-address stack with one-shot checkpoint/restore
// Optional checkpoint/restore path enabled by macro RAS_CKPT_RESTORE_EN.
module ras_ckpt_stack #(
  parameter int RAS_DEPTH = 2,
  parameter int VLEN      = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [VLEN-1:0] data_i,
  input  logic            ckpt_save_i,
  input  logic            ckpt_restore_i,
  output logic            valid_o,
  output logic [VLEN-1:0] ra_o,
  output logic            overflow_o,
  output logic            underflow_o
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [VLEN-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] tos;
  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] tos_inc;
  logic [PTR_W-1:0] tos_dec;

`ifdef RAS_CKPT_RESTORE_EN
  logic [PTR_W-1:0] snap_tos;
  logic [CNT_W-1:0] snap_cnt;
  logic [VLEN-1:0]  snap_top;
  logic             snap_valid;
`else
  logic unused_ckpt;
  assign unused_ckpt = ckpt_save_i ^ ckpt_restore_i;
`endif

  // Explicit wrap so non-power-of-two depths stay inside the array.
  assign tos_inc = (tos == PTR_W'(RAS_DEPTH - 1)) ? '0 : tos + 1'b1;
  assign tos_dec = (tos == '0) ? PTR_W'(RAS_DEPTH - 1) : tos - 1'b1;

  assign valid_o = (cnt != '0);
  assign ra_o    = valid_o ? mem[tos] : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RAS_DEPTH; i++) mem[i] <= '0;
      tos         <= '0;
      cnt         <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
`ifdef RAS_CKPT_RESTORE_EN
      snap_tos    <= '0;
      snap_cnt    <= '0;
      snap_top    <= '0;
      snap_valid  <= 1'b0;
`endif
    end else begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
      if (flush_i) begin
        cnt <= '0;
`ifdef RAS_CKPT_RESTORE_EN
        snap_valid <= 1'b0;
`endif
      end
`ifdef RAS_CKPT_RESTORE_EN
      else if (ckpt_restore_i && snap_valid) begin
        // Rewrites the top slot too, undoing a speculative push over it.
        tos            <= snap_tos;
        cnt            <= snap_cnt;
        mem[snap_tos]  <= snap_top;
        snap_valid     <= 1'b0;
      end
`endif
      else begin
`ifdef RAS_CKPT_RESTORE_EN
        if (ckpt_save_i) begin
          snap_tos   <= tos;
          snap_cnt   <= cnt;
          snap_top   <= mem[tos];
          snap_valid <= 1'b1;
        end
`endif
        if (push_i && pop_i && (cnt != '0)) begin
          mem[tos] <= data_i;
        end else if (push_i) begin
          tos          <= tos_inc;
          mem[tos_inc] <= data_i;
          if (cnt == CNT_W'(RAS_DEPTH)) overflow_o <= 1'b1;
          else                          cnt        <= cnt + 1'b1;
        end else if (pop_i) begin
          if (cnt != '0) begin
            tos <= tos_dec;
            cnt <= cnt - 1'b1;
          end else begin
            underflow_o <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ras_ckpt_stack.sv
// tb/tb_ras_ckpt_stack.sv - scoreboard bench for ras_ckpt_stack (RAS_DEPTH=2)
module tb_ras_ckpt_stack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush, push, pop, save, restore;
  logic [31:0] data;
  logic        valid, ovf, unf;
  logic [31:0] ra;

  typedef struct {
    string       nm;
    logic        v;
    logic [31:0] ra;
    logic        ov;
    logic        un;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  ras_ckpt_stack #(.RAS_DEPTH(2), .VLEN(32)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .push_i         (push),
    .pop_i          (pop),
    .data_i         (data),
    .ckpt_save_i    (save),
    .ckpt_restore_i (restore),
    .valid_o        (valid),
    .ra_o           (ra),
    .overflow_o     (ovf),
    .underflow_o    (unf)
  );

  always #5 clk = ~clk;

  task automatic expect_out(input string nm, input logic v, input logic [31:0] r,
                            input logic ov, input logic un);
    exp_t e;
    e.nm = nm; e.v = v; e.ra = r; e.ov = ov; e.un = un;
    exp_q.push_back(e);
  endtask

  // One request cycle: drive on the falling edge, expectation describes the following cycle.
  task automatic step(input string nm, input logic fl, input logic pu, input logic po,
                      input logic [31:0] d, input logic sv, input logic rs,
                      input logic v, input logic [31:0] r, input logic ov, input logic un);
    @(negedge clk);
    flush = fl; push = pu; pop = po; data = d; save = sv; restore = rs;
    expect_out(nm, v, r, ov, un);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (valid !== e.v || ra !== e.ra || ovf !== e.ov || unf !== e.un) begin
          bad++;
          $display("FAIL %s: got valid=%0b ra=%h ovf=%0b unf=%0b, want valid=%0b ra=%h ovf=%0b unf=%0b",
                   e.nm, valid, ra, ovf, unf, e.v, e.ra, e.ov, e.un);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] exp_restore;
    flush = 0; push = 0; pop = 0; data = '0; save = 0; restore = 0;
    #2;
    expect_out("reset", 0, 32'h0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // basic push/pop
    step("t1_push100", 0,1,0,32'h100,0,0, 1,32'h100,0,0);
    step("t1_push200", 0,1,0,32'h200,0,0, 1,32'h200,0,0);
    step("t1_pop1",    0,0,1,32'h0,  0,0, 1,32'h100,0,0);
    step("t1_pop2",    0,0,1,32'h0,  0,0, 0,32'h0,  0,0);

    // overflow wrap
    step("t2_push100", 0,1,0,32'h100,0,0, 1,32'h100,0,0);
    step("t2_push200", 0,1,0,32'h200,0,0, 1,32'h200,0,0);
    step("t2_push300", 0,1,0,32'h300,0,0, 1,32'h300,1,0);
    step("t2_pop1",    0,0,1,32'h0,  0,0, 1,32'h200,0,0);
    step("t2_pop2",    0,0,1,32'h0,  0,0, 0,32'h0,  0,0);

    // underflow
    step("t3_pop_empty", 0,0,1,32'h0, 0,0, 0,32'h0, 0,1);
    step("t3_idle",      0,0,0,32'h0, 0,0, 0,32'h0, 0,0);
    step("t3_push40",    0,1,0,32'h40,0,0, 1,32'h40,0,0);

    // simultaneous push/pop
    step("t4_flush",    1,0,0,32'h0, 0,0, 0,32'h0, 0,0);
    step("t4_push10",   0,1,0,32'h10,0,0, 1,32'h10,0,0);
    step("t4_push20",   0,1,0,32'h20,0,0, 1,32'h20,0,0);
    step("t4_pushpop",  0,1,1,32'h30,0,0, 1,32'h30,0,0);
    step("t4_pop1",     0,0,1,32'h0, 0,0, 1,32'h10,0,0);
    step("t4_pop2",     0,0,1,32'h0, 0,0, 0,32'h0, 0,0);
    step("t4_pushpop_empty", 0,1,1,32'h77,0,0, 1,32'h77,0,0);
    step("t4_flush2",   1,0,0,32'h0, 0,0, 0,32'h0, 0,0);

    // checkpoint repair of a speculatively overwritten top
`ifdef RAS_CKPT_RESTORE_EN
    exp_restore = 32'h20;
`else
    exp_restore = 32'h99;
`endif
    step("t5_push10",  0,1,0,32'h10,0,0, 1,32'h10,0,0);
    step("t5_push20",  0,1,0,32'h20,0,0, 1,32'h20,0,0);
    step("t5_save",    0,0,0,32'h0, 1,0, 1,32'h20,0,0);
    step("t5_pop",     0,0,1,32'h0, 0,0, 1,32'h10,0,0);
    step("t5_push99",  0,1,0,32'h99,0,0, 1,32'h99,0,0);
    step("t5_restore", 0,0,0,32'h0, 0,1, 1,exp_restore,0,0);
    step("t5_pop_after", 0,0,1,32'h0,0,0, 1,32'h10,0,0);
    step("t5_restore_spent_push55", 0,1,0,32'h55,0,1, 1,32'h55,0,0);
    step("t5_flush",   1,0,0,32'h0, 0,0, 0,32'h0, 0,0);

    // flush invalidates the snapshot
    step("t6_push11",  0,1,0,32'h11,0,0, 1,32'h11,0,0);
    step("t6_save",    0,0,0,32'h0, 1,0, 1,32'h11,0,0);
    step("t6_flush",   1,0,0,32'h0, 0,0, 0,32'h0, 0,0);
    step("t6_restore_push5", 0,1,0,32'h5,0,1, 1,32'h5,0,0);
    step("t6_push66",  0,1,0,32'h66,0,0, 1,32'h66,0,0);

    // asynchronous reset mid-sequence
    @(negedge clk);
    flush = 0; push = 0; pop = 0; data = '0; save = 0; restore = 0;
    #2;
    expect_out("t6_async_reset", 0, 32'h0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step("t6_idle_after_rst", 0,0,0,32'h0,0,0, 0,32'h0,0,0);
    step("t6_push7",   0,1,0,32'h7,0,0, 1,32'h7,0,0);
    step("t6_pop7",    0,0,1,32'h0,0,0, 0,32'h0,0,0);
    step("t6_restore_after_rst", 0,0,0,32'h0,0,1, 0,32'h0,0,0);

    @(negedge clk);
    flush = 0; push = 0; pop = 0; save = 0; restore = 0;
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
